// File: rtl/digit_serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor: FSM encoding,
// counter sizing and the one-bit full subtractor used by the digit slice.
package digit_serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that must represent 0..n (CLOG2(n+1)), never below 1.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // One-bit full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

endpackage

// File: rtl/digit_serial_sub_digit.sv
// Combinational DIGIT-bit ripple subtractor slice: {bout, d} = x - y - bin.
module sub_digit
  import digit_serial_sub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  // Borrow ripples LSB to MSB through the full-subtractor chain.
  always_comb begin
    logic c;
    c = bin;
    d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      {c, d[i]} = full_sub(x[i], y[i], c);
    end
    bout = c;
  end

endmodule

// File: rtl/digit_serial_sub.sv
// Multi-cycle subtractor: dif = a - b - bin over WIDTH bits, DIGIT bits per
// clock, LSB digit first, with start/busy/done handshake and held results.
module digit_serial_sub
  import digit_serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bor,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("digit_serial_sub: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_dig;
  logic             b_out;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;
  logic             last;
  logic             run;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .bin  (brw),
    .d    (d_dig),
    .bout (b_out)
  );

  assign run  = (state == ST_RUN);
  assign last = (cnt == CW'(N - 1));

  // The partial result fills from the MSB side; only its upper WIDTH-DIGIT
  // bits need storing, the newest digit comes straight from the slice.
  if (DIGIT == WIDTH) begin : g_single
    assign res_next = d_dig;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] res_sh;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_sh <= '0;
      end else if (run) begin
        res_sh <= res_next[WIDTH-1:DIGIT];
      end else begin
        res_sh <= res_sh;
      end
    end

    assign res_next = {d_dig, res_sh};
  end

  assign ovf_next = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);

  // FSM, operand shifters, digit counter and held output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dif   <= '0;
      bor   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          brw  <= b_out;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            dif   <= res_next;
            bor   <= b_out;
            ovf   <= ovf_next;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
